cs8_stream_packer: RTL and testbench

//   Sequences the cs12->cs8 sample reducer for the RX sample path. Takes one
//   12-bit signed I/Q pair per handshake and emits 32-bit words: cs16 mode gives
//   one sign-extended pair per word; cs8 mode gives two rounded, saturated pairs
//   per word. Frames output into FRAME_WORDS-word bursts with m_last, and

---
 rtl/cs8_stream_packer.sv | 174 +++++++++++++++++
 tb/tb_cs8_stream_packer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cs8_stream_packer.sv
// cs8_stream_packer
//   Packs 12-bit signed I/Q pairs from the RX sample path into 32-bit words.
//   cs16 mode: one sign-extended pair per word, {sext16(q), sext16(i)}.
//   cs8 mode : two rounded/saturated 8-bit pairs per word; first pair in
//              [15:0], second pair in [31:16].
//   Output words are framed into FRAME_WORDS-word bursts (m_last on the final
//   word). The packing mode is only re-latched at a frame boundary.
//
// Ports
//   clk, rstn        clock, asynchronous active-low reset
//   cfg_en           1 = run; 0 = drop any held half word and restart the frame
//   cfg_cs8          requested packing mode (1 = cs8, 0 = cs16)
//   flush            level; emits a pending cs8 half word padded with zeros
//   s_valid/s_ready  input pair handshake, s_i/s_q two's complement samples
//   m_valid/m_ready  output word handshake, m_data packed word, m_last frame end
//   sat_cnt          count of clamped cs8 lanes, sticks at all-ones
module cs8_stream_packer #(
  parameter int unsigned FRAME_WORDS = 1024,
  parameter int unsigned SAT_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 cfg_en,
  input  logic                 cfg_cs8,
  input  logic                 flush,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [11:0]          s_i,
  input  logic [11:0]          s_q,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [31:0]          m_data,
  output logic                 m_last,
  output logic [SAT_CNT_W-1:0] sat_cnt
);

  localparam int unsigned WCNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(FRAME_WORDS - 1);

  typedef enum logic {
    ST_EMPTY,
    ST_HALF
  } state_e;

  state_e                 state_q, state_d;
  logic [WCNT_W-1:0]      word_cnt_q, word_cnt_d;
  logic                   mode_q, mode_d;
  logic [15:0]            half_q, half_d;
  logic                   m_valid_q, m_valid_d;
  logic [31:0]            m_data_q, m_data_d;
  logic                   m_last_q, m_last_d;
  logic [SAT_CNT_W-1:0]   sat_cnt_q, sat_cnt_d;

  logic                   slot_free;
  logic                   accept;
  logic                   at_boundary;
  logic                   mode_eff;
  logic                   flush_fire;
  logic                   load;
  logic [8:0]             rs_i, rs_q;
  logic [1:0]             sat_inc;
  logic [SAT_CNT_W:0]     sat_sum;

  // Returns {clamped, lane}: round-half-up to 8 bits, clamped to [-128,127].
  function automatic logic [8:0] round_sat8(input logic [11:0] x);
    logic [8:0] sum;
    sum = {x[11], x[11:4]} + {8'd0, x[3]};
    if (sum[8] != sum[7]) begin
      return {1'b1, (sum[8] ? 8'h80 : 8'h7F)};
    end
    return {1'b0, sum[7:0]};
  endfunction

  // ---------------------------------------------------------------- handshake
  assign slot_free   = !m_valid_q || m_ready;
  assign s_ready     = rstn && cfg_en && !flush && slot_free;
  assign accept      = s_valid && s_ready;
  assign at_boundary = (state_q == ST_EMPTY) && (word_cnt_q == '0);
  // At a frame boundary the requested mode applies to this very accept, so the
  // first pair of a frame is already packed in the newly latched mode.
  assign mode_eff    = at_boundary ? cfg_cs8 : mode_q;
  assign flush_fire  = cfg_en && flush && (state_q == ST_HALF) && slot_free;

  assign rs_i    = round_sat8(s_i);
  assign rs_q    = round_sat8(s_q);
  assign sat_inc = {1'b0, rs_i[8]} + {1'b0, rs_q[8]};
  assign sat_sum = {1'b0, sat_cnt_q} + (SAT_CNT_W + 1)'(sat_inc);

  // ----------------------------------------------------------- state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_EMPTY;
      word_cnt_q <= '0;
      mode_q     <= 1'b0;
      half_q     <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
      sat_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      mode_q     <= mode_d;
      half_q     <= half_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    if (!cfg_en) begin
      state_d = ST_EMPTY;
    end else if (accept && mode_eff) begin
      state_d = (state_q == ST_EMPTY) ? ST_HALF : ST_EMPTY;
    end else if (flush_fire) begin
      state_d = ST_EMPTY;
    end
  end

  // ----------------------------------------------------------------- datapath
  always_comb begin
    load       = 1'b0;
    mode_d     = mode_q;
    half_d     = half_q;
    m_valid_d  = m_valid_q && !m_ready;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    word_cnt_d = word_cnt_q;
    sat_cnt_d  = sat_cnt_q;

    if (!cfg_en || at_boundary) begin
      mode_d = cfg_cs8;
    end

    if (cfg_en && accept) begin
      if (!mode_eff) begin
        load     = 1'b1;
        m_data_d = {{4{s_q[11]}}, s_q, {4{s_i[11]}}, s_i};
      end else begin
        sat_cnt_d = sat_sum[SAT_CNT_W] ? '1 : sat_sum[SAT_CNT_W-1:0];
        if (state_q == ST_EMPTY) begin
          half_d = {rs_q[7:0], rs_i[7:0]};
        end else begin
          load     = 1'b1;
          m_data_d = {rs_q[7:0], rs_i[7:0], half_q};
        end
      end
    end else if (flush_fire) begin
      load     = 1'b1;
      m_data_d = {16'h0000, half_q};
    end

    if (load) begin
      m_valid_d  = 1'b1;
      m_last_d   = (word_cnt_q == WCNT_LAST);
      word_cnt_d = (word_cnt_q == WCNT_LAST) ? '0 : word_cnt_q + 1'b1;
    end

    if (!cfg_en) begin
      word_cnt_d = '0;
    end
  end

  // ------------------------------------------------------------------ outputs
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign sat_cnt = sat_cnt_q;

endmodule

// File: tb/tb_cs8_stream_packer.sv
// Testbench for cs8_stream_packer: directed scenarios plus randomized traffic,
// checked against a queue-based reference model of the packing rules.
module tb_cs8_stream_packer;

  localparam int unsigned FW = 4;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cfg_en, cfg_cs8, flush;
  logic          s_valid, s_ready;
  logic [11:0]   s_i, s_q;
  logic          m_valid, m_ready, m_last;
  logic [31:0]   m_data;
  logic [SW-1:0] sat_cnt;

  always #5 clk = ~clk;

  cs8_stream_packer #(.FRAME_WORDS(FW), .SAT_CNT_W(SW)) dut (
    .clk(clk), .rstn(rstn), .cfg_en(cfg_en), .cfg_cs8(cfg_cs8), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_i(s_i), .s_q(s_q),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .sat_cnt(sat_cnt)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  // ------------------------------------------------------------ reference model
  logic [32:0]  exp_q[$];   // {last, word}
  bit           mdl_half;
  logic [15:0]  mdl_held;
  int unsigned  mdl_wcnt;
  bit           mdl_mode;
  int unsigned  mdl_sat;
  logic [31:0]  last_word;
  bit           last_flag;
  int unsigned  words_out = 0;
  bit           acc_seen;

  // Nearest-integer of x/16 with halves rounded up, clamped to int8.
  function automatic logic [7:0] ref_lane(input logic [11:0] x, output bit clamped);
    int xi, v;
    xi = int'($signed(x));
    v  = (xi + 8) >>> 4;
    clamped = (v > 127) || (v < -128);
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return 8'(v);
  endfunction

  function automatic logic [15:0] sext16(input logic [11:0] x);
    return 16'(int'($signed(x)));
  endfunction

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back({(mdl_wcnt == FW - 1), w});
    mdl_wcnt = (mdl_wcnt + 1) % FW;
  endtask

  task automatic model_reset();
    exp_q.delete();
    mdl_half = 0; mdl_held = '0; mdl_wcnt = 0; mdl_mode = 0; mdl_sat = 0;
  endtask

  // One clock: check at the falling edge, advance the model, then move past
  // the rising edge so the caller can drive the next inputs.
  task automatic step();
    bit mv, sf, rdy, acc, ci, cq;
    logic [32:0] w;
    logic [7:0] li, lq;
    @(negedge clk);
    mv  = (exp_q.size() != 0);
    sf  = !mv || m_ready;
    rdy = cfg_en && !flush && sf;
    check("s_ready", s_ready, rdy);
    check("m_valid", m_valid, mv);
    check("sat_cnt", sat_cnt, mdl_sat);
    if (mv && m_ready) begin
      w = exp_q.pop_front();
      check("m_data", m_data, w[31:0]);
      check("m_last", m_last, w[32]);
      last_word = m_data;
      last_flag = m_last;
      words_out++;
    end
    acc = s_valid && rdy;
    if (acc) acc_seen = 1;
    if (!cfg_en) begin
      mdl_half = 0; mdl_wcnt = 0; mdl_mode = cfg_cs8;
    end else begin
      if (!mdl_half && mdl_wcnt == 0) mdl_mode = cfg_cs8;
      if (acc) begin
        if (!mdl_mode) begin
          push_word({sext16(s_q), sext16(s_i)});
        end else begin
          li = ref_lane(s_i, ci);
          lq = ref_lane(s_q, cq);
          mdl_sat += int'(ci) + int'(cq);
          if (mdl_sat > (2**SW) - 1) mdl_sat = (2**SW) - 1;
          if (!mdl_half) begin
            mdl_held = {lq, li};
            mdl_half = 1;
          end else begin
            push_word({lq, li, mdl_held});
            mdl_half = 0;
          end
        end
      end else if (flush && mdl_half && sf) begin
        push_word({16'h0000, mdl_held});
        mdl_half = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input logic [11:0] i, input logic [11:0] q);
    s_i = i; s_q = q; s_valid = 1'b1; acc_seen = 0;
    for (int k = 0; k < 64 && !acc_seen; k++) step();
    s_valid = 1'b0;
    check("accept_timeout", acc_seen, 1);
  endtask

  task automatic wait_words(input int unsigned target);
    for (int k = 0; k < 64 && words_out < target; k++) step();
    check("out_timeout", (words_out >= target), 1);
  endtask

  task automatic restart(input bit cs8);
    cfg_cs8 = cs8; cfg_en = 1'b0;
    step();
    cfg_en = 1'b1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    model_reset();
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 32'h0);
    check("rst_m_last", m_last, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    check("rst_s_ready", s_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] held_data;
  int unsigned base;

  initial begin
    cfg_en = 1'b1; cfg_cs8 = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    s_i = '0; s_q = '0;
    do_reset();

    // cs16 extremes
    send_pair(12'h800, 12'h7FF);
    wait_words(1);
    check("t1_data", last_word, 32'h07FF_F800);

    // cs8 rounding
    restart(1);
    send_pair(12'h018, 12'h7F7);
    send_pair(12'hFF8, 12'h000);
    wait_words(2);
    check("t2_data", last_word, 32'h0000_7F02);
    send_pair(12'h7F8, 12'h808);
    step();
    check("t2_sat", sat_cnt, 1);
    send_pair(12'h000, 12'h000);
    wait_words(3);
    check("t2_data_b", last_word, 32'h0000_817F);

    // backpressure
    restart(1);
    m_ready = 1'b0;
    send_pair(12'h123, 12'h456);
    send_pair(12'h789, 12'hABC);
    step();
    held_data = m_data;
    s_i = 12'h111; s_q = 12'h222; s_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t3_hold", m_data, held_data);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    base = words_out;
    for (int k = 0; k < 8; k++) send_pair(12'(k * 96 + 5), 12'(12'hF00 - k * 77));
    wait_words(base + 5);

    // framing and mode change at the boundary
    restart(1);
    base = words_out;
    for (int k = 0; k < 8; k++) begin
      send_pair(12'(k * 40), 12'(k * 13 + 1));
      if (k == 2) cfg_cs8 = 1'b0;
    end
    wait_words(base + 4);
    check("t4_last", last_flag, 1);
    send_pair(12'h123, 12'h9AB);
    wait_words(base + 5);
    check("t4_cs16", last_word, 32'hF9AB_0123);
    check("t4_last_b", last_flag, 0);

    // flush
    restart(1);
    send_pair(12'h100, 12'h200);
    base = words_out;
    flush = 1'b1;
    wait_words(base + 1);
    check("t5_data", last_word, 32'h0000_2010);
    repeat (3) step();
    check("t5_noout", words_out, base + 1);
    flush = 1'b0;

    // cfg_en drop while holding a half word
    restart(1);
    send_pair(12'h3F0, 12'h0F0);
    base = words_out;
    cfg_en = 1'b0;
    repeat (2) step();
    check("t6_noout", words_out, base);
    cfg_en = 1'b1;
    send_pair(12'h010, 12'h020);
    send_pair(12'h030, 12'h040);
    wait_words(base + 1);
    check("t6_last", last_flag, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 15) == 0);
      cfg_en  = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 31) == 0) cfg_cs8 = ~cfg_cs8;
      s_i = ($urandom_range(0, 3) == 0) ? 12'(12'h7F8 + $urandom_range(0, 7)) : 12'($urandom);
      s_q = ($urandom_range(0, 3) == 0) ? 12'(12'h800 + $urandom_range(0, 15)) : 12'($urandom);
      step();
    end
    check("sat_max", sat_cnt, (2**SW) - 1);

    // reset with a word pending
    s_valid = 1'b0; flush = 1'b0; cfg_en = 1'b1; m_ready = 1'b0;
    repeat (2) step();
    m_ready = 1'b1;
    restart(0);
    m_ready = 1'b0;
    send_pair(12'h555, 12'hAAA);
    step();
    check("t7_pending", m_valid, 1);
    do_reset();
    m_ready = 1'b1;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
